// File: rtl/acc_arbiter.sv
// rtl/acc_arbiter.sv - two-port round-robin arbiter for a shared signed add/sub accumulator
module acc_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] data1,
  input  logic             clr,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] acc,
  output logic             res_valid,
  output logic             carry,
  output logic             overflow,
  output logic             halted,
  output logic             owner
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  state_t           state_q, state_d;
  logic             op_q;
  logic [WIDTH-1:0] opnd_q;
  logic             prio_q;

  logic             grant_any;
  logic             grant_sel;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic             c;
  logic             ovf;

  always_comb begin
    grant_sel = (req0 && req1) ? prio_q : req1;
    grant_any = (state_q == IDLE) && !clr && (req0 || req1);

    // Subtraction at WIDTH+1 bits leaves the borrow in the top bit.
    sum = op_q ? ({1'b0, acc} - {1'b0, opnd_q}) : ({1'b0, acc} + {1'b0, opnd_q});
    r   = sum[MSB:0];
    c   = sum[WIDTH];
    if (op_q) ovf = (acc[MSB] != opnd_q[MSB]) && (r[MSB] != acc[MSB]);
    else      ovf = (acc[MSB] == opnd_q[MSB]) && (r[MSB] != acc[MSB]);

    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    state_d = (!clr && ovf) ? HALT : IDLE;
      HALT:    if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      opnd_q    <= '0;
      prio_q    <= 1'b0;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      acc       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt0      <= grant_any && !grant_sel;
      gnt1      <= grant_any && grant_sel;
      res_valid <= 1'b0;
      if (grant_any) begin
        op_q   <= grant_sel ? op1 : op0;
        opnd_q <= grant_sel ? data1 : data0;
        owner  <= grant_sel;
        prio_q <= ~grant_sel;
      end
      // clr beats a command in flight; the granted command is simply dropped.
      if (clr) begin
        acc      <= '0;
        carry    <= 1'b0;
        overflow <= 1'b0;
      end else if (state_q == EXEC) begin
        acc       <= r;
        carry     <= c;
        overflow  <= ovf;
        res_valid <= 1'b1;
      end
    end
  end

  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_acc_arbiter.sv
// tb/tb_acc_arbiter.sv - scoreboard bench for acc_arbiter
module tb_acc_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0, clr = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       gnt0, gnt1, res_valid, carry, overflow, halted, owner;
  logic [7:0] acc;

  acc_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .data0(data0),
    .req1(req1), .op1(op1), .data1(data1),
    .clr(clr),
    .gnt0(gnt0), .gnt1(gnt1), .acc(acc), .res_valid(res_valid),
    .carry(carry), .overflow(overflow), .halted(halted), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       owner;
    logic [7:0] acc;
    logic       carry;
    logic       ovf;
  } res_t;

  res_t       res_q[$];
  logic       gnt_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_acc   = '0;
  logic       m_prio  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned range decides carry/borrow, signed range decides overflow.
  function automatic void model(input logic port, input logic op, input logic [7:0] d);
    int   ua, ub, us, sa, sb, ss;
    res_t e;
    ua = m_acc;
    ub = d;
    sa = $signed(m_acc);
    sb = $signed(d);
    if (op) begin
      us = ua - ub;
      ss = sa - sb;
      e.carry = (ua < ub);
    end else begin
      us = ua + ub;
      ss = sa + sb;
      e.carry = (us > 255);
    end
    e.acc   = us[7:0];
    e.ovf   = (ss > 127) || (ss < -128);
    e.owner = port;
    m_acc   = e.acc;
    m_prio  = ~port;
    res_q.push_back(e);
    gnt_q.push_back(port);
  endfunction

  logic prev_rv = 1'b0;
  logic prev_g  = 1'b0;

  always @(negedge clk) begin : monitor
    logic ge;
    res_t re;
    if (gnt0 || gnt1) begin
      chk("gnt_onehot", gnt0 & gnt1, 0);
      chk("gnt_gap", prev_g, 0);
      if (gnt_q.size() == 0) chk("gnt_unexpected", 1, 0);
      else begin
        ge = gnt_q.pop_front();
        chk("gnt_port", gnt1, ge);
      end
    end
    if (res_valid) begin
      chk("rv_single", prev_rv, 0);
      if (res_q.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        re = res_q.pop_front();
        chk("res_acc", acc, re.acc);
        chk("res_carry", carry, re.carry);
        chk("res_ovf", overflow, re.ovf);
        chk("res_owner", owner, re.owner);
        chk("res_halted", halted, re.ovf);
      end
    end
    prev_rv = res_valid;
    prev_g  = gnt0 | gnt1;
  end

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) chk("gnt_timeout", 1, 0);
  endtask

  task automatic cmd(input logic port, input logic op, input logic [7:0] d);
    int c;
    @(posedge clk); #1;
    model(port, op, d);
    if (port) begin req1 = 1'b1; op1 = op; data1 = d; end
    else      begin req0 = 1'b1; op0 = op; data0 = d; end
    wait_gnt(c);
    chk("gnt_latency", c, 2);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_acc", acc, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_halted", halted, 0);
    chk("rst_owner", owner, 0);
    m_acc  = '0;
    m_prio = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_acc", acc, 0);
    chk("clr_carry", carry, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_halted", halted, 0);
    m_acc = '0;
  endtask

  initial begin
    int c, ng;

    // basic add then subtract with borrow
    do_reset();
    cmd(0, 0, 8'h05);
    cmd(1, 1, 8'h07);

    // both ports held: round-robin alternation
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) model(m_prio, 0, m_prio ? 8'h02 : 8'h01);
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h01;
    req1 = 1'b1; op1 = 1'b0; data1 = 8'h02;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) ng++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("rr_grants", ng, 4);
    @(negedge clk);
    chk("rr_acc", acc, 8'h06);

    // positive overflow halts; requests ignored until clr
    do_reset();
    cmd(0, 0, 8'h64);
    cmd(0, 0, 8'h64);
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h01; data1 = 8'h01;
    repeat (10) @(negedge clk);
    chk("halt_acc", acc, 8'hC8);
    chk("halt_flag", halted, 1);
    chk("halt_ovf", overflow, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    do_clr();
    cmd(1, 0, 8'h03);

    // negative-side overflow cases
    do_reset();
    cmd(0, 0, 8'h80);
    cmd(0, 1, 8'h01);
    do_clr();
    cmd(0, 1, 8'h80);
    do_clr();

    // clr during EXEC discards the command
    cmd(0, 0, 8'h20);
    @(posedge clk); #1;
    gnt_q.push_back(1'b0);
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h10;
    wait_gnt(c);
    chk("clrx_gnt", c, 2);
    clr = 1'b1;
    req0 = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clrx_rv", res_valid, 0);
    chk("clrx_acc", acc, 0);
    chk("clrx_halted", halted, 0);
    m_acc = '0;
    cmd(1, 0, 8'h05);

    // rst during EXEC drops the command and restores prio
    do_reset();
    cmd(0, 0, 8'h11);
    @(posedge clk); #1;
    gnt_q.push_back(1'b0);
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h22;
    wait_gnt(c);
    chk("rstx_gnt", c, 2);
    rst = 1'b1;
    req0 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstx_gnt0", gnt0, 0);
    chk("rstx_gnt1", gnt1, 0);
    chk("rstx_acc", acc, 0);
    chk("rstx_rv", res_valid, 0);
    chk("rstx_owner", owner, 0);
    chk("rstx_halted", halted, 0);
    m_acc  = '0;
    m_prio = 1'b0;
    @(posedge clk); #1;
    model(m_prio, 0, 8'h01);
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h01;
    req1 = 1'b1; op1 = 1'b0; data1 = 8'h02;
    wait_gnt(c);
    chk("rstx_prio_gnt0", gnt0, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);

    chk("res_q_empty", res_q.size(), 0);
    chk("gnt_q_empty", gnt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
